// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter.
//   pc_op_e   : next-PC operation selected for the coming clock edge
//   decode_op : strict-priority decode of the decoder control bits into pc_op_e
//               (reset is handled directly by the registers, not here)
package pc_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_RET,
    OP_CALL,
    OP_ABS,
    OP_REL,
    OP_INC
  } pc_op_e;

  // Priority: stall > ret > call > absolute jump > relative jump > increment.
  // ret beats call, so asserting both performs only the return.
  function automatic pc_op_e decode_op(
    input logic stall,
    input logic ret_en,
    input logic call_en,
    input logic branch_en,
    input logic absjump_en,
    input logic reljump_en
  );
    if (stall)                          return OP_HOLD;
    else if (ret_en)                    return OP_RET;
    else if (call_en)                   return OP_CALL;
    else if (branch_en && absjump_en)   return OP_ABS;
    else if (branch_en && reljump_en)   return OP_REL;
    else                                return OP_INC;
  endfunction

endpackage

// File: rtl/pc_ras_if.sv
// Decoder <-> PC/RAS control and status bundle.
// Control semantics: there is no valid/ready handshake. The decoder (master)
// presents one set of control bits every cycle; they are consumed at every
// rising clk edge, and the status (slave outputs) reflects that edge's
// operation from the following cycle on. stall freezes everything.
//   master : drives stall, branch_en, reljump_en, absjump_en, call_en, ret_en,
//            target; observes prog_ctr, ras_count, ras_empty, ras_full,
//            ras_overflow, ras_underflow
//   slave  : the mirror image, used by pc_ras
interface pc_ras_if #(
  parameter int D     = 12,
  parameter int DEPTH = 4
);
  logic                       stall;
  logic                       branch_en;
  logic                       reljump_en;
  logic                       absjump_en;
  logic                       call_en;
  logic                       ret_en;
  logic [D-1:0]               target;
  logic [D-1:0]               prog_ctr;
  logic [$clog2(DEPTH+1)-1:0] ras_count;
  logic                       ras_empty;
  logic                       ras_full;
  logic                       ras_overflow;
  logic                       ras_underflow;

  modport master (
    output stall, branch_en, reljump_en, absjump_en, call_en, ret_en, target,
    input  prog_ctr, ras_count, ras_empty, ras_full, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, branch_en, reljump_en, absjump_en, call_en, ret_en, target,
    output prog_ctr, ras_count, ras_empty, ras_full, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/ras_stack.sv
// Return-address stack: circular LIFO of DEPTH entries, D bits each.
//   clk, reset : clock, synchronous active-high reset (empties the stack)
//   push       : write push_data as the new top; when full the oldest entry is
//                overwritten and count stays at DEPTH
//   pop        : drop the top entry; ignored when empty
//   top        : current top entry (meaningless when empty)
//   count      : number of valid entries, 0..DEPTH
//   full/empty : count == DEPTH / count == 0
// push and pop are never asserted together by pc_ras; push wins if they are.
module ras_stack #(
  parameter int D     = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [D-1:0]               push_data,
  output logic [D-1:0]               top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [$clog2(DEPTH+1)-1:0] MAX_CNT = ($clog2(DEPTH+1))'(DEPTH);

  logic [D-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;   // next slot to write
  logic [PW-1:0] top_ptr;  // slot just below wr_ptr, wrapping

  // Explicit wrap so non-power-of-two depths work.
  assign top_ptr = (wr_ptr == '0) ? LAST : wr_ptr - 1'b1;
  assign top     = mem[top_ptr];
  assign full    = (count == MAX_CNT);
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      // When full, wr_ptr already points at the oldest entry, so advancing
      // past it is exactly the circular overwrite.
      wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (!full) count <= count + 1'b1;
    end else if (pop && !empty) begin
      wr_ptr <= top_ptr;
      count  <= count - 1'b1;
    end
  end

  // Storage needs no reset: entries above count are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_ras.sv
// Fetch-stage program counter with integrated return-address stack.
//   clk, reset : clock, synchronous active-high reset
//   bus        : pc_ras_if slave -- decoder controls in, PC and RAS status out
// Holds the PC register, the increment/relative adders, the next-PC mux and the
// sticky overflow/underflow flags; the stack itself lives in ras_stack.
// All arithmetic wraps modulo 2^D.
module pc_ras
  import pc_pkg::*;
#(
  parameter int           D          = 12,
  parameter int           DEPTH      = 4,
  parameter logic [D-1:0] START_ADDR = '0
) (
  input logic     clk,
  input logic     reset,
  pc_ras_if.slave bus
);
  pc_op_e                     op;
  logic [D-1:0]               pc_q;
  logic [D-1:0]               pc_inc;
  logic [D-1:0]               pc_rel;
  logic [D-1:0]               pc_next;
  logic [D-1:0]               ras_top;
  logic [$clog2(DEPTH+1)-1:0] ras_count;
  logic                       ras_full;
  logic                       ras_empty;
  logic                       ovf_q;
  logic                       unf_q;

  assign op = decode_op(bus.stall, bus.ret_en, bus.call_en, bus.branch_en,
                        bus.absjump_en, bus.reljump_en);

  assign pc_inc = pc_q + 1'b1;
  assign pc_rel = pc_q + bus.target;  // target is a two's-complement offset

  ras_stack #(
    .D     (D),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (op == OP_CALL),
    .pop       (op == OP_RET),
    .push_data (pc_inc),
    .top       (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  always_comb begin
    pc_next = pc_q;
    case (op)
      OP_HOLD: pc_next = pc_q;
      OP_RET:  pc_next = ras_empty ? pc_inc : ras_top;  // empty return just steps on
      OP_CALL: pc_next = bus.target;
      OP_ABS:  pc_next = bus.target;
      OP_REL:  pc_next = pc_rel;
      OP_INC:  pc_next = pc_inc;
      default: pc_next = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= START_ADDR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q <= pc_next;
      if (op == OP_CALL && ras_full)  ovf_q <= 1'b1;
      if (op == OP_RET  && ras_empty) unf_q <= 1'b1;
    end
  end

  assign bus.prog_ctr      = pc_q;
  assign bus.ras_count     = ras_count;
  assign bus.ras_empty     = ras_empty;
  assign bus.ras_full      = ras_full;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_ras.sv
// Directed bench for pc_ras (D=12, DEPTH=4, START_ADDR=0).
// The driver applies one vector per cycle on the falling edge and queues the
// hand-computed state expected after the next rising edge; the monitor pops
// one expectation after every rising edge that has one pending.
module tb_pc_ras;
  localparam int D     = 12;
  localparam int DEPTH = 4;
  localparam int W     = D + 3 + 4;  // pc, count, empty, full, ovf, unf

  logic clk;
  logic reset;

  pc_ras_if #(.D(D), .DEPTH(DEPTH)) bus ();

  pc_ras #(
    .D          (D),
    .DEPTH      (DEPTH),
    .START_ADDR (12'h000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int vecs = 0;
  int errs = 0;
  logic eo;  // expected ras_overflow
  logic eu;  // expected ras_underflow

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [W-1:0] exp_w;
      logic [W-1:0] got_w;
      exp_w = exp_q.pop_front();
      got_w = {bus.prog_ctr, bus.ras_count, bus.ras_empty, bus.ras_full,
               bus.ras_overflow, bus.ras_underflow};
      vecs++;
      if (got_w !== exp_w) begin
        errs++;
        $display("FAIL vec%0d: got pc=%h cnt=%0d e/f/o/u=%b expected pc=%h cnt=%0d e/f/o/u=%b",
                 vecs, got_w[W-1 -: D], got_w[6:4], got_w[3:0],
                 exp_w[W-1 -: D], exp_w[6:4], exp_w[3:0]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic v(input string kind, input logic [D-1:0] tgt,
                   input logic [D-1:0] e_pc, input logic [2:0] e_cnt);
    logic e_empty;
    logic e_full;
    @(negedge clk);
    reset          = 1'b0;
    bus.stall      = 1'b0;
    bus.branch_en  = 1'b0;
    bus.reljump_en = 1'b0;
    bus.absjump_en = 1'b0;
    bus.call_en    = 1'b0;
    bus.ret_en     = 1'b0;
    bus.target     = tgt;
    case (kind)
      "rst":      reset = 1'b1;
      "rstcall":  begin reset = 1'b1; bus.call_en = 1'b1; end
      "rststall": begin reset = 1'b1; bus.stall = 1'b1; bus.ret_en = 1'b1; end
      "rel":      begin bus.branch_en = 1'b1; bus.reljump_en = 1'b1; end
      "abs":      begin bus.branch_en = 1'b1; bus.absjump_en = 1'b1; end
      "both":     begin bus.branch_en = 1'b1; bus.absjump_en = 1'b1; bus.reljump_en = 1'b1; end
      "br":       bus.branch_en = 1'b1;
      "call":     bus.call_en = 1'b1;
      "ret":      bus.ret_en = 1'b1;
      "cr":       begin bus.call_en = 1'b1; bus.ret_en = 1'b1; end
      "stall":    begin bus.stall = 1'b1; bus.branch_en = 1'b1; bus.absjump_en = 1'b1; end
      default:    ;  // idle
    endcase
    e_empty = (e_cnt == 3'd0);
    e_full  = (e_cnt == 3'd4);
    exp_q.push_back({e_pc, e_cnt, e_empty, e_full, eo, eu});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset          = 1'b1;
    bus.stall      = 1'b0;
    bus.branch_en  = 1'b0;
    bus.reljump_en = 1'b0;
    bus.absjump_en = 1'b0;
    bus.call_en    = 1'b0;
    bus.ret_en     = 1'b0;
    bus.target     = '0;
    eo = 1'b0;
    eu = 1'b0;

    v("rst",  12'h000, 12'h000, 3'd0);
    v("rst",  12'h000, 12'h000, 3'd0);
    // jumps and increments
    v("rel",  12'h004, 12'h004, 3'd0);
    v("abs",  12'h008, 12'h008, 3'd0);
    v("idle", 12'h000, 12'h009, 3'd0);
    v("idle", 12'h000, 12'h00A, 3'd0);
    v("idle", 12'h000, 12'h00B, 3'd0);
    v("rel",  12'hFFD, 12'h008, 3'd0);   // 11 - 3
    v("abs",  12'h002, 12'h002, 3'd0);
    v("rel",  12'hFFC, 12'hFFE, 3'd0);   // 2 - 4 wraps
    v("idle", 12'h000, 12'hFFF, 3'd0);
    v("idle", 12'h000, 12'h000, 3'd0);   // FFF + 1 wraps to 0
    v("br",   12'h055, 12'h001, 3'd0);   // branch_en alone just increments
    v("both", 12'h008, 12'h008, 3'd0);   // absolute wins (relative would give 9)
    // single call / return
    v("call", 12'h100, 12'h100, 3'd1);
    v("ret",  12'h000, 12'h009, 3'd0);
    // five nested calls from 10,20,30,40,50
    v("abs",  12'd10,  12'd10,  3'd0);
    v("call", 12'd20,  12'd20,  3'd1);
    v("call", 12'd30,  12'd30,  3'd2);
    v("call", 12'd40,  12'd40,  3'd3);
    v("call", 12'd50,  12'd50,  3'd4);
    eo = 1'b1;
    v("call", 12'h300, 12'h300, 3'd4);   // return address 11 overwritten
    v("ret",  12'h000, 12'd51,  3'd3);
    v("ret",  12'h000, 12'd41,  3'd2);
    v("ret",  12'h000, 12'd31,  3'd1);
    v("ret",  12'h000, 12'd21,  3'd0);
    eu = 1'b1;
    v("ret",  12'h000, 12'd22,  3'd0);
    // stall, then call+ret together
    eo = 1'b0;
    eu = 1'b0;
    v("rst",   12'h000, 12'h000, 3'd0);
    v("call",  12'h080, 12'h080, 3'd1);  // pushes 1
    v("stall", 12'h200, 12'h080, 3'd1);
    v("stall", 12'h200, 12'h080, 3'd1);
    v("stall", 12'h200, 12'h080, 3'd1);
    v("cr",    12'h200, 12'h001, 3'd0);  // return only, no push, no overflow
    // build count 3 with both flags set
    eu = 1'b1;
    v("ret",  12'h000, 12'h002, 3'd0);
    v("call", 12'h010, 12'h010, 3'd1);
    v("call", 12'h020, 12'h020, 3'd2);
    v("call", 12'h030, 12'h030, 3'd3);
    v("call", 12'h040, 12'h040, 3'd4);
    eo = 1'b1;
    v("call", 12'h050, 12'h050, 3'd4);   // pushes 0x41 over 0x3
    v("ret",  12'h000, 12'h041, 3'd3);
    // reset overrides everything
    eo = 1'b0;
    eu = 1'b0;
    v("rstcall",  12'h123, 12'h000, 3'd0);
    v("idle",     12'h000, 12'h001, 3'd0);
    v("rststall", 12'h000, 12'h000, 3'd0);
    v("idle",     12'h000, 12'h001, 3'd0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      vecs++;
      errs++;
      $display("FAIL drain: got %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/pc_ras.md
# pc_ras

Parametrised program counter with an integrated return-address stack (RAS). It is the next generation of the core's fetch-stage PC. It keeps relative and absolute jumps and adds stall, subroutine call and return, with a configurable hardware stack and error flags. It drives the instruction-memory address and takes its control inputs from the decoder.

## Interface
Parameters:
- `D`, 12, PC/address width in bits
- `DEPTH`, 4, RAS entries (≥2)
- `START_ADDR`, 0, PC value after reset

Ports:
- `clk`  in  1  clock; all state updates on its rising edge
- `reset`  in  1  reset, synchronous and active-high
- `stall`  in  1  hold PC and stack; all other controls ignored
- `branch_en`  in  1  qualifies `reljump_en` and `absjump_en`
- `reljump_en`  in  1  relative jump, taken only with `branch_en`
- `absjump_en`  in  1  absolute jump, taken only with `branch_en`
- `call_en`  in  1  push return address, then jump absolute to `target`
- `ret_en`  in  1  pop return address into the PC
- `target`  in  D  jump/call address; signed two's-complement offset for relative jumps
- `prog_ctr`  out  D  current PC (registered)
- `ras_count`  out  $clog2(DEPTH+1)  valid stack entries
- `ras_empty`  out  1  `ras_count == 0`
- `ras_full`  out  1  `ras_count == DEPTH`
- `ras_overflow`  out  1  sticky: a call was made while the stack was full
- `ras_underflow`  out  1  sticky: a return was made while the stack was empty

## Operation
The next-state operation is chosen by strict priority, highest first:
1. `reset`: `prog_ctr` ← `START_ADDR`; stack emptied; `ras_count` = 0; both sticky flags cleared.
2. `stall`: PC, stack, count and flags all held.
3. `ret_en`:
   - Stack non-empty: `prog_ctr` ← top entry; count decremented.
   - Stack empty: `prog_ctr` ← `prog_ctr` + 1; `ras_underflow` ← 1.
4. `call_en`: push `prog_ctr` + 1; `prog_ctr` ← `target`.
   - Stack full: the oldest entry is discarded (circular overwrite); count stays at `DEPTH`; `ras_overflow` ← 1; the jump is still taken.
5. `branch_en & absjump_en`: `prog_ctr` ← `target`. Absolute wins if both jump enables are set.
6. `branch_en & reljump_en`: `prog_ctr` ← `prog_ctr` + `target`.
7. Otherwise: `prog_ctr` ← `prog_ctr` + 1. This includes `branch_en` asserted with neither jump enable.

Rules:
- Arithmetic: all sums are D bits, modulo 2^D. No carry out, no saturation. Incrementing 2^D−1 gives 0.
- `call_en` and `ret_en` together: the return executes and the call is ignored. No push occurs and the call does not set `ras_overflow`.
- Sticky flags clear only on `reset`.
- Stack entries beyond `ras_count` are don't-care and must never be observed.

## Timing
- Inputs are sampled at the rising edge. `prog_ctr` shows the result one cycle later, with no additional latency for any operation.
- The return target is the top entry as stored in registers. A call at edge N followed by a return at edge N+1 returns to the address pushed at N.
- `ras_count`, `ras_empty`, `ras_full` and both flags are registered and update on the same edge as `prog_ctr`.
- Reset values: `prog_ctr` = `START_ADDR`, `ras_count` = 0, `ras_empty` = 1, `ras_full` = 0, `ras_overflow` = 0, `ras_underflow` = 0.
- Reset asserted mid-operation, including during a stall, takes effect at the next edge regardless of the other inputs.

## Structure
- Package `pc_pkg`:
  - enum `pc_op_e` (`OP_HOLD`, `OP_RET`, `OP_CALL`, `OP_ABS`, `OP_REL`, `OP_INC`)
  - a priority-decode function from the control bits to `pc_op_e`
- Sub-module `ras_stack`, parametrised by `D` and `DEPTH`:
  - LIFO with push, pop, top, count, full and empty
  - circular overwrite on a push when full
- The `pc_ras` top level holds the PC register, the adder, the next-PC mux and the sticky flags.

## Test plan
Defaults throughout: D=12, DEPTH=4, START_ADDR=0.
- Reset, then relative jump +4 → 4; absolute jump to 8 → 8; three idle cycles → 9, 10, 11.
- At PC 11, relative jump with `target` = 12'hFFD → 8; at PC 2, relative jump with 12'hFFC → 12'hFFE. Then an increment from 12'hFFF → 0.
- Call at PC 8 with `target` 12'h100 → PC 12'h100, count 1. Return → PC 9, count 0, `ras_empty` = 1.
- Five nested calls from PCs 10, 20, 30, 40, 50:
  - `ras_overflow` rises after the 5th call; count stays 4.
  - Four returns → 51, 41, 31, 21.
  - A fifth return → previous PC + 1 with `ras_underflow` = 1.
- `stall` held for 3 cycles with `branch_en` & `absjump_en` and `target` 12'h200 → PC and count unchanged. Then `call_en` and `ret_en` together with count 1 → PC = popped address, count 0, no push, `ras_overflow` unchanged.
- With count 3 and both flags set, assert `reset` for one cycle alongside `call_en` → PC 0, count 0, `ras_empty` 1, both flags 0.
